// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults for the integer register file.
//   XLEN_DEF / NREG_DEF : default data width and register count
//   RF_RESET_VAL        : per-register reset image (x28=6, x22=4, x18=6, rest 0)
//   rf_reset_val()      : safe lookup that returns 0 for x0 and for
//                         registers beyond the table (larger NREG builds)
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int RV_AW    = $clog2(NREG_DEF);

    localparam logic [31:0] RF_RESET_VAL [NREG_DEF] = '{
        28:      32'd6,
        22:      32'd4,
        18:      32'd6,
        default: 32'd0
    };

    function automatic logic [31:0] rf_reset_val(input int k);
        logic [RV_AW-1:0] idx;
        idx = k[RV_AW-1:0];
        if (k > 0 && k < NREG_DEF)
            return RF_RESET_VAL[idx];
        return 32'd0;
    endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// regfile_sb_cnt: pending-write counter for one architectural register.
//   clk, rst : clock, synchronous active-high reset
//   inc      : a new write to this register was issued
//   dec      : a pending write to this register retired
//   flush    : squash, clears the count (overrides inc/dec)
//   cnt      : current number of outstanding writes
// inc and dec together cancel. The counter saturates at both ends
// rather than wrapping.
module regfile_sb_cnt #(
    parameter int PCW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    input  logic           dec,
    input  logic           flush,
    output logic [PCW-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || flush)
            cnt <= '0;
        else if (inc && !dec && cnt != '1)
            cnt <= cnt + PCW'(1);
        else if (dec && !inc && cnt != '0)
            cnt <= cnt - PCW'(1);
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with a per-register pending-write
// scoreboard, sitting between issue (reads, destination allocation) and
// writeback (retire).
//   clk, rst      : clock, synchronous active-high reset
//   rd_addr/data  : NRD combinational read ports, port i at [i*AW +: AW]
//                   and [i*XLEN +: XLEN]
//   rd_busy       : port's register still has writes outstanding after
//                   any retire happening this cycle
//   wr_en/addr/data : writeback retire
//   alloc_en/addr : issue claims a destination; alloc_ready says accepted
//   flush         : clears every pending count
//   err_underflow : sticky, a retire hit a register with no pending write
// Build option: define REGFILE_BYPASS_EN for write-first reads (a same-
// cycle writeback is forwarded to rd_data); otherwise reads return the
// pre-write value.
module regfile_sb import regfile_pkg::*; #(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    parameter  int PCW  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    output logic              alloc_ready,
    input  logic              flush,
    output logic              err_underflow
);

    // x0 is kept as a real entry that is only ever loaded with 0, so
    // reads of x0 need no special mux.
    logic [XLEN-1:0] regs [NREG];
    logic [PCW-1:0]  cnt  [NREG];
    logic [NREG-1:1] inc, dec;
    logic            wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    // A full counter can still take a new alloc when the same register
    // retires this cycle: the two cancel and the count holds.
    assign alloc_ready = !((alloc_addr != '0) && (cnt[alloc_addr] == '1) &&
                           !(wr_en && wr_addr == alloc_addr));

    always_comb begin
        inc = '0;
        dec = '0;
        for (int k = 1; k < NREG; k++) begin
            inc[k] = alloc_en && alloc_ready && (alloc_addr == AW'(k));
            dec[k] = wr_en && (wr_addr == AW'(k)) && (cnt[k] != '0);
        end
    end

    assign cnt[0] = '0;

    for (genvar k = 1; k < NREG; k++) begin : g_cnt
        regfile_sb_cnt #(.PCW(PCW)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc[k]),
            .dec   (dec[k]),
            .flush (flush),
            .cnt   (cnt[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++)
                regs[k] <= XLEN'(rf_reset_val(k));
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Underflow still flags under flush; the write itself always lands.
    always_ff @(posedge clk) begin
        if (rst)
            err_underflow <= 1'b0;
        else if (wr_live && cnt[wr_addr] == '0)
            err_underflow <= 1'b1;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          dec_same;

        assign a        = rd_addr[i*AW +: AW];
        assign dec_same = wr_en && (wr_addr == a) && (cnt[a] != '0);
        // Busy only if writes remain after the one retiring right now.
        assign rd_busy[i] = (cnt[a] - PCW'(dec_same)) != '0;
`ifdef REGFILE_BYPASS_EN
        assign rd_data[i*XLEN +: XLEN] = (wr_live && wr_addr == a) ? wr_data : regs[a];
`else
        assign rd_data[i*XLEN +: XLEN] = regs[a];
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed test-plan sequence with literal expectations,
// followed by randomized traffic compared every cycle against a
// behavioural model (register array + pending-write counts).
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int PCW  = 2;
    localparam int AW   = 5;
    localparam int MAXC = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [XLEN-1:0]      wr_data;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_addr;
    logic                 alloc_ready;
    logic                 flush;
    logic                 err_underflow;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .PCW(PCW)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_busy       (rd_busy),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .alloc_en      (alloc_en),
        .alloc_addr    (alloc_addr),
        .alloc_ready   (alloc_ready),
        .flush         (flush),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          mvalid = 1'b0;
    logic [31:0] mreg [NREG];
    int          mcnt [NREG];
    bit          merr;
    bit          m_ok;

    function automatic logic exp_ready();
        return !(alloc_addr != 0 && mcnt[alloc_addr] == MAXC &&
                 !(wr_en && wr_addr == alloc_addr));
    endfunction

    function automatic logic [31:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return 32'd0;
        if (BYP && wr_en && wr_addr == a) return wr_data;
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        int pend;
        pend = mcnt[a];
        if (wr_en && wr_addr == a && a != 0 && pend > 0) pend = pend - 1;
        return pend != 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                mreg[k] = 32'd0;
                mcnt[k] = 0;
            end
            mreg[28] = 32'd6;
            mreg[22] = 32'd4;
            mreg[18] = 32'd6;
            merr   = 1'b0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            m_ok = exp_ready();
            if (wr_en && wr_addr != 0) begin
                if (mcnt[wr_addr] == 0) merr = 1'b1;
                else mcnt[wr_addr] = mcnt[wr_addr] - 1;
                mreg[wr_addr] = wr_data;
            end
            if (alloc_en && m_ok && alloc_addr != 0)
                mcnt[alloc_addr] = mcnt[alloc_addr] + 1;
            if (flush)
                for (int k = 0; k < NREG; k++) mcnt[k] = 0;
        end
    end

    // Single compare process: every output, every cycle, against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < NRD; i++) begin
                chk($sformatf("model rd_data[%0d]", i), 64'(rd_data[i*XLEN +: XLEN]),
                    64'(exp_data(rd_addr[i*AW +: AW])));
                chk($sformatf("model rd_busy[%0d]", i), 64'(rd_busy[i]),
                    64'(exp_busy(rd_addr[i*AW +: AW])));
            end
            chk("model alloc_ready", 64'(alloc_ready), 64'(exp_ready()));
            chk("model err_underflow", 64'(err_underflow), 64'(merr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; alloc_en = 1'b0; flush = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic do_wr(input logic [AW-1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic do_alloc(input logic [AW-1:0] a);
        alloc_en = 1'b1; alloc_addr = a;
    endtask

    function automatic logic [AW-1:0] pick();
        case ($urandom_range(0, 5))
            0: return AW'($urandom_range(0, NREG - 1));
            1: return AW'(0);
            2: return AW'(3);
            3: return AW'(7);
            4: return AW'(9);
            default: return AW'(28);
        endcase
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset image
        set_rd(28, 22);
        @(negedge clk);
        chk("reset x28", 64'(rd_data[31:0]), 64'd6);
        chk("reset x22", 64'(rd_data[63:32]), 64'd4);
        chk("reset busy", 64'(rd_busy), 64'd0);
        chk("reset alloc_ready", 64'(alloc_ready), 64'd1);
        chk("reset err", 64'(err_underflow), 64'd0);
        nxt(); set_rd(18, 5);
        @(negedge clk);
        chk("reset x18", 64'(rd_data[31:0]), 64'd6);
        chk("reset x5", 64'(rd_data[63:32]), 64'd0);

        // 2: x0 is hardwired
        nxt(); do_wr(0, 32'hDEADBEEF); set_rd(0, 0);
        @(negedge clk);
        chk("x0 during write", 64'(rd_data[31:0]), 64'd0);
        nxt(); @(negedge clk);
        chk("x0 after write", 64'(rd_data[31:0]), 64'd0);
        nxt(); do_alloc(0);
        @(negedge clk);
        chk("alloc x0 ready", 64'(alloc_ready), 64'd1);
        nxt(); @(negedge clk);
        chk("x0 busy", 64'(rd_busy[0]), 64'd0);

        // 3: read/write same cycle
        nxt(); do_alloc(5);
        nxt(); do_wr(5, 32'h1234); set_rd(5, 5);
        @(negedge clk);
        chk("x5 same-cycle read", 64'(rd_data[31:0]), BYP ? 64'h1234 : 64'd0);
        chk("x5 last retire not busy", 64'(rd_busy[0]), 64'd0);
        nxt(); @(negedge clk);
        chk("x5 next cycle", 64'(rd_data[31:0]), 64'h1234);
        chk("x5 no underflow", 64'(err_underflow), 64'd0);

        // 4: saturation of x7
        set_rd(7, 7);
        repeat (3) begin nxt(); do_alloc(7); end
        nxt(); do_alloc(7);
        @(negedge clk);
        chk("x7 4th alloc ready", 64'(alloc_ready), 64'd0);
        chk("x7 busy full", 64'(rd_busy[0]), 64'd1);
        nxt(); do_wr(7, 32'h77); do_alloc(7);
        @(negedge clk);
        chk("x7 retire+alloc ready", 64'(alloc_ready), 64'd1);
        chk("x7 retire+alloc busy", 64'(rd_busy[0]), 64'd1);
        for (int j = 0; j < 3; j++) begin
            nxt(); do_wr(7, 32'h70 + 32'(j));
            @(negedge clk);
            chk($sformatf("x7 retire %0d busy", j), 64'(rd_busy[0]), (j < 2) ? 64'd1 : 64'd0);
        end
        nxt(); @(negedge clk);
        chk("x7 idle busy", 64'(rd_busy[0]), 64'd0);
        chk("x7 value", 64'(rd_data[31:0]), 64'h72);

        // 5: flush beats same-cycle alloc
        nxt(); do_alloc(9);
        nxt(); do_alloc(9);
        nxt(); flush = 1'b1; do_alloc(9); set_rd(9, 9);
        @(negedge clk);
        chk("x9 busy before flush", 64'(rd_busy[0]), 64'd1);
        nxt(); @(negedge clk);
        chk("x9 busy after flush", 64'(rd_busy[0]), 64'd0);

        // 6: underflow
        nxt(); do_wr(11, 32'h55); set_rd(11, 11);
        @(negedge clk);
        chk("err not yet", 64'(err_underflow), 64'd0);
        nxt(); @(negedge clk);
        chk("x11 written", 64'(rd_data[31:0]), 64'h55);
        chk("err set", 64'(err_underflow), 64'd1);
        repeat (3) nxt();
        @(negedge clk);
        chk("err sticky", 64'(err_underflow), 64'd1);
        nxt(); rst = 1'b1;
        nxt(); set_rd(11, 28);
        @(negedge clk);
        chk("err cleared", 64'(err_underflow), 64'd0);
        chk("x11 reset", 64'(rd_data[31:0]), 64'd0);
        chk("x28 reset", 64'(rd_data[63:32]), 64'd6);

        // randomized traffic, checked by the compare process
        for (int n = 0; n < 3000; n++) begin
            nxt();
            rst        = ($urandom_range(0, 199) == 0);
            flush      = ($urandom_range(0, 24) == 0);
            wr_en      = $urandom_range(0, 1) == 1;
            wr_addr    = pick();
            wr_data    = $urandom;
            alloc_en   = $urandom_range(0, 2) != 0;
            alloc_addr = pick();
            set_rd(pick(), pick());
        end
        nxt();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
